// File: rtl/hp_bars_pkg.sv
// rtl/hp_bars_pkg.sv - shared types, colours and helpers for the health-bar engine
package hp_bars_pkg;

  typedef enum logic [1:0] {ALIVE, INVULN, KO} hp_state_t;

  localparam logic [11:0] COL_HP    = 12'hF00;
  localparam logic [11:0] COL_GHOST = 12'hFFF;
  localparam logic [11:0] COL_FRAME = 12'hFC0;

  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a - b : 16'd0;
  endfunction

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing and colour bundle with input/output views
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/hp_channel.sv
// rtl/hp_channel.sv - one player's HP, ghost bar and ALIVE/INVULN/KO FSM (HP_BLINK_EN adds blink)
module hp_channel
  import hp_bars_pkg::*;
#(
  parameter int HP_W       = 10,
  parameter int HP_MAX     = 500,
  parameter int DAMAGE     = 100,
  parameter int IFRAMES    = 30,
  parameter int DRAIN_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hit,
  input  logic            reset_hp,
  input  logic            frame_tick,
  output logic [HP_W-1:0] hp,
  output logic [HP_W-1:0] ghost,
  output hp_state_t       state,
  output logic            blink
);

  localparam int CNT_W = ($clog2(IFRAMES + 1) < 3) ? 3 : $clog2(IFRAMES + 1);

  hp_state_t       state_n;
  logic [HP_W-1:0] hp_n;
  logic [HP_W-1:0] ghost_n;
  logic [HP_W-1:0] drained;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ALIVE;
      hp    <= HP_W'(HP_MAX);
      ghost <= HP_W'(HP_MAX);
      cnt   <= '0;
    end else begin
      state <= state_n;
      hp    <= hp_n;
      ghost <= ghost_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    hp_n    = hp;
    ghost_n = ghost;
    cnt_n   = cnt;
    drained = HP_W'(sat_sub(16'(ghost), 16'(DRAIN_STEP)));
    if (reset_hp) begin
      state_n = ALIVE;
      hp_n    = HP_W'(HP_MAX);
      ghost_n = HP_W'(HP_MAX);
      cnt_n   = '0;
    end else begin
      case (state)
        ALIVE: begin
          if (hit) begin
            hp_n = HP_W'(sat_sub(16'(hp), 16'(DAMAGE)));
            if (hp_n == '0) begin
              state_n = KO;
            end else begin
              state_n = INVULN;
              cnt_n   = CNT_W'(IFRAMES);
            end
          end
        end
        INVULN: begin
          if (frame_tick) begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state_n = ALIVE;
            end
          end
        end
        default: ;
      endcase
      // Ghost trails the post-hit HP so it can never sit below the live bar
      if (frame_tick) begin
        ghost_n = (hp_n > drained) ? hp_n : drained;
      end
    end
  end

`ifdef HP_BLINK_EN
  assign blink = (state == INVULN) && cnt[2];
`else
  assign blink = 1'b0;
`endif

endmodule

// File: rtl/hp_bars_multi.sv
// rtl/hp_bars_multi.sv - N-player health-bar overlay on the VGA stream, one cycle latency (HP_BLINK_EN optional)
module hp_bars_multi
  import hp_bars_pkg::*;
#(
  parameter int N_PLAYERS  = 2,
  parameter int HP_W       = 10,
  parameter int HP_MAX     = 500,
  parameter int DAMAGE     = 100,
  parameter int IFRAMES    = 30,
  parameter int DRAIN_STEP = 4,
  parameter int BAR_X0     = 8,
  parameter int BAR_PITCH  = 508,
  parameter int BAR_Y0     = 6,
  parameter int BAR_Y1     = 26,
  parameter int FRM_X0     = 3,
  parameter int FRM_X1     = 1020,
  parameter int FRM_Y0     = 3,
  parameter int FRM_Y1     = 29
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PLAYERS-1:0]      hit,
  input  logic                      reset_hp,
  output logic [N_PLAYERS*HP_W-1:0] hp,
  output logic [N_PLAYERS-1:0]      ko,
  vga_if.vga_in                     vga_in,
  vga_if.vga_out                    vga_out
);

  logic            frame_tick;
  logic [HP_W-1:0] ch_hp    [N_PLAYERS];
  logic [HP_W-1:0] ch_ghost [N_PLAYERS];
  hp_state_t       ch_state [N_PLAYERS];
  logic [N_PLAYERS-1:0] ch_blink;

  assign frame_tick = (vga_in.vcount == 11'd0) && (vga_in.hcount == 11'd0);

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_ch
    hp_channel #(
      .HP_W       (HP_W),
      .HP_MAX     (HP_MAX),
      .DAMAGE     (DAMAGE),
      .IFRAMES    (IFRAMES),
      .DRAIN_STEP (DRAIN_STEP)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .hit        (hit[g]),
      .reset_hp   (reset_hp),
      .frame_tick (frame_tick),
      .hp         (ch_hp[g]),
      .ghost      (ch_ghost[g]),
      .state      (ch_state[g]),
      .blink      (ch_blink[g])
    );
    assign hp[g*HP_W +: HP_W] = ch_hp[g];
    assign ko[g]              = (ch_state[g] == KO);
  end

  logic [10:0] x, y, base, span_end, h, gv;
  logic [10:0] hp_lo, hp_hi, gh_lo, gh_hi;
  logic        in_rows, hp_on, ghost_on, frame_on;
  logic [11:0] rgb_mux;

  always_comb begin
    x        = vga_in.hcount;
    y        = vga_in.vcount;
    in_rows  = (y >= 11'(BAR_Y0)) && (y < 11'(BAR_Y1));
    frame_on = (x >= 11'(FRM_X0)) && (x < 11'(FRM_X1)) &&
               (y >= 11'(FRM_Y0)) && (y < 11'(FRM_Y1));
    hp_on    = 1'b0;
    ghost_on = 1'b0;
    base     = '0;
    span_end = '0;
    h        = '0;
    gv       = '0;
    hp_lo    = '0;
    hp_hi    = '0;
    gh_lo    = '0;
    gh_hi    = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      base     = 11'(BAR_X0 + i * BAR_PITCH);
      span_end = base + 11'(HP_MAX);
      h        = 11'(ch_hp[i]);
      gv       = 11'(ch_ghost[i]);
      // Even bars shrink toward their right edge, odd bars toward their left
      if ((i % 2) == 0) begin
        hp_lo = span_end - h;
        hp_hi = span_end;
        gh_lo = span_end - gv;
        gh_hi = span_end - h;
      end else begin
        hp_lo = base;
        hp_hi = base + h;
        gh_lo = base + h;
        gh_hi = base + gv;
      end
      if (in_rows && (x >= hp_lo) && (x < hp_hi) && !ch_blink[i]) hp_on = 1'b1;
      if (in_rows && (x >= gh_lo) && (x < gh_hi)) ghost_on = 1'b1;
    end
    if (hp_on)         rgb_mux = COL_HP;
    else if (ghost_on) rgb_mux = COL_GHOST;
    else if (frame_on) rgb_mux = COL_FRAME;
    else               rgb_mux = vga_in.rgb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= vga_in.hcount;
      vga_out.vcount <= vga_in.vcount;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.vblnk  <= vga_in.vblnk;
      vga_out.rgb    <= rgb_mux;
    end
  end

endmodule

// File: tb/tb_hp_bars_multi.sv
// tb/tb_hp_bars_multi.sv - randomized scoreboard bench for hp_bars_multi against a segment-level model
module tb_hp_bars_multi;
  localparam int HPMAX = 500;
  localparam int DMG   = 100;
  localparam int IFR   = 30;
  localparam int DRN   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] hit = 2'b00;
  logic       reset_hp = 1'b0;
  logic [19:0] hp;
  logic [1:0] ko;

  vga_if in_if ();
  vga_if out_if ();

  hp_bars_multi dut (
    .clk      (clk),
    .rst      (rst),
    .hit      (hit),
    .reset_hp (reset_hp),
    .hp       (hp),
    .ko       (ko),
    .vga_in   (in_if),
    .vga_out  (out_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic [3:0]  sync;
    logic [11:0] rgb;
    int          hp0;
    int          hp1;
    logic [1:0]  ko;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Model state: 0 alive, 1 invulnerable, 2 knocked out
  int m_hp[2], m_gh[2], m_st[2], m_cnt[2];

  int px_tab[12] = '{8, 5, 1020, 107, 108, 516, 515, 1015, 1016, 507, 508, 2};
  int py_tab[12] = '{10, 4, 10, 10, 10, 10, 25, 6, 26, 5, 28, 10};

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic logic [11:0] model_pixel(input int x, input int y, input logic [11:0] bg);
    bit rows, hon, gon, fon;
    int base, hl, hh, gl, gh;
    rows = (y >= 6) && (y < 26);
    fon  = (x >= 3) && (x < 1020) && (y >= 3) && (y < 29);
    hon = 0;
    gon = 0;
    for (int c = 0; c < 2; c++) begin
      bit hide;
      base = 8 + c * 508;
      if (c % 2 == 0) begin
        hh = base + HPMAX; hl = hh - m_hp[c]; gl = hh - m_gh[c]; gh = hl;
      end else begin
        hl = base; hh = base + m_hp[c]; gl = hh; gh = base + m_gh[c];
      end
`ifdef HP_BLINK_EN
      hide = (m_st[c] == 1) && (((m_cnt[c] >> 2) & 1) == 1);
`else
      hide = 0;
`endif
      if (rows && x >= hl && x < hh && !hide) hon = 1;
      if (rows && x >= gl && x < gh) gon = 1;
    end
    if (hon) return 12'hF00;
    if (gon) return 12'hFFF;
    if (fon) return 12'hFC0;
    return bg;
  endfunction

  task automatic model_step(input logic [1:0] h, input logic rh, input bit tick);
    for (int c = 0; c < 2; c++) begin
      if (rh) begin
        m_hp[c] = HPMAX; m_gh[c] = HPMAX; m_st[c] = 0; m_cnt[c] = 0;
      end else begin
        if (m_st[c] == 0 && h[c]) begin
          m_hp[c] = (m_hp[c] > DMG) ? m_hp[c] - DMG : 0;
          if (m_hp[c] == 0) m_st[c] = 2;
          else begin m_st[c] = 1; m_cnt[c] = IFR; end
        end else if (m_st[c] == 1 && tick) begin
          m_cnt[c] = m_cnt[c] - 1;
          if (m_cnt[c] == 0) m_st[c] = 0;
        end
        if (tick) begin
          int d;
          d = (m_gh[c] > DRN) ? m_gh[c] - DRN : 0;
          m_gh[c] = (m_hp[c] > d) ? m_hp[c] : d;
        end
      end
    end
  endtask

  task automatic cycle(input logic [1:0] h, input logic rh, input int px, input int py);
    exp_t e;
    @(negedge clk);
    in_if.hcount = 11'(px);
    in_if.vcount = 11'(py);
    in_if.hsync  = 1'($urandom_range(0, 1));
    in_if.vsync  = 1'($urandom_range(0, 1));
    in_if.hblnk  = 1'($urandom_range(0, 1));
    in_if.vblnk  = 1'($urandom_range(0, 1));
    in_if.rgb    = 12'($urandom);
    hit      = h;
    reset_hp = rh;
    e.hc   = in_if.hcount;
    e.vc   = in_if.vcount;
    e.sync = {in_if.hsync, in_if.vsync, in_if.hblnk, in_if.vblnk};
    e.rgb  = model_pixel(px, py, in_if.rgb);
    model_step(h, rh, (px == 0 && py == 0));
    e.hp0 = m_hp[0];
    e.hp1 = m_hp[1];
    e.ko  = {m_st[1] == 2, m_st[0] == 2};
    sb.push_back(e);
  endtask

  task automatic rnd_xy(output int px, output int py);
    if ($urandom_range(0, 1) == 1) begin
      int k;
      k  = $urandom_range(0, 11);
      px = px_tab[k];
      py = py_tab[k];
    end else begin
      px = $urandom_range(1, 1100);
      py = $urandom_range(0, 35);
    end
  endtask

  task automatic frame(input logic [1:0] h);
    int px, py;
    rnd_xy(px, py);
    cycle(h, 1'b0, px, py);
    repeat (3) begin
      rnd_xy(px, py);
      cycle(2'b00, 1'b0, px, py);
    end
    cycle(2'b00, 1'b0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("vga_timing", int'({out_if.hcount, out_if.vcount, out_if.hsync, out_if.vsync,
                              out_if.hblnk, out_if.vblnk}),
          int'({e.hc, e.vc, e.sync}));
      chk("rgb", int'(out_if.rgb), int'(e.rgb));
      chk("hp0", int'(hp[9:0]), e.hp0);
      chk("hp1", int'(hp[19:10]), e.hp1);
      chk("ko", int'(ko), int'(e.ko));
    end
  end

  initial begin
    int px, py;
    in_if.hcount = 11'd5; in_if.vcount = 11'd5;
    in_if.hsync = 0; in_if.vsync = 0; in_if.hblnk = 0; in_if.vblnk = 0;
    in_if.rgb = 12'h123;
    for (int c = 0; c < 2; c++) begin
      m_hp[c] = HPMAX; m_gh[c] = HPMAX; m_st[c] = 0; m_cnt[c] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", int'(out_if.rgb), 0);
    chk("reset_timing", int'({out_if.hcount, out_if.vcount, out_if.hsync, out_if.vsync,
                              out_if.hblnk, out_if.vblnk}), 0);
    chk("reset_hp", int'(hp), (500 << 10) | 500);
    chk("reset_ko", int'(ko), 0);
    @(negedge clk);
    rst = 1'b0;

    repeat (2) frame(2'b00);
    frame(2'b01);
    settle();
    chk("hit0_once", int'(hp[9:0]), 400);
    repeat (26) frame(2'b00);

    cycle(2'b00, 1'b1, 8, 10);
    repeat (3) cycle(2'b01, 1'b0, 107, 10);
    repeat (10) frame(2'b00);
    frame(2'b01);
    settle();
    chk("hit0_invuln_ignored", int'(hp[9:0]), 400);
    repeat (22) frame(2'b00);
    frame(2'b01);
    settle();
    chk("hit0_after_iframes", int'(hp[9:0]), 300);

    cycle(2'b00, 1'b1, 516, 10);
    repeat (5) begin
      frame(2'b10);
      repeat (31) frame(2'b00);
    end
    settle();
    chk("hp1_ko_value", int'(hp[19:10]), 0);
    chk("ko1_set", int'(ko), 2);
    frame(2'b10);
    repeat (30) frame(2'b00);
    settle();
    chk("hp1_ko_stays", int'(hp[19:10]), 0);

    cycle(2'b00, 1'b1, 8, 10);
    frame(2'b01);
    repeat (32) frame(2'b00);
    cycle(2'b01, 1'b1, 108, 10);
    settle();
    chk("reset_hp_wins", int'(hp[9:0]), 500);
    chk("reset_hp_ko", int'(ko), 0);
    cycle(2'b01, 1'b0, 108, 10);
    settle();
    chk("alive_after_reset_hp", int'(hp[9:0]), 400);

    repeat (200) begin
      if ($urandom_range(0, 39) == 0) begin
        rnd_xy(px, py);
        cycle(2'($urandom_range(0, 3)), 1'b1, px, py);
      end
      frame(($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
